// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard controller bus.
// Groups the hazard-detection inputs and the per-stage enable/flush outputs
// of pipe_hazard_ctrl.
//   master : the pipeline side. It drives the hazard inputs and receives the
//            enables, flushes, Mem_Timeout and Stall_Cnt.
//   slave  : the controller side. It is the mirror of master.
interface pipe_hazard_ctrl_if;
  // Instruction in ID
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        ID_Use_Rs;
  logic        ID_Use_Rt;
  logic        ID_Branch_Taken;
  // Instruction in EX
  logic [4:0]  E_Rd;
  logic        E_Wreg;
  logic        E_Reg2reg;
  // Data memory
  logic        M_Mem_Req;
  logic        Mem_Ready;
  // Per-stage controls
  logic        PC_We;
  logic        IF_ID_We;
  logic        ID_EX_We;
  logic        EX_MEM_We;
  logic        MEM_WB_We;
  logic        IF_ID_Flush;
  logic        ID_EX_Flush;
  logic        MEM_WB_Flush;
  // Status
  logic        Mem_Timeout;
  logic [15:0] Stall_Cnt;

  modport master (
    output ID_Rs, ID_Rt, ID_Use_Rs, ID_Use_Rt, ID_Branch_Taken,
           E_Rd, E_Wreg, E_Reg2reg, M_Mem_Req, Mem_Ready,
    input  PC_We, IF_ID_We, ID_EX_We, EX_MEM_We, MEM_WB_We,
           IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush, Mem_Timeout, Stall_Cnt
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_Use_Rs, ID_Use_Rt, ID_Branch_Taken,
           E_Rd, E_Wreg, E_Reg2reg, M_Mem_Req, Mem_Ready,
    output PC_We, IF_ID_We, ID_EX_We, EX_MEM_We, MEM_WB_We,
           IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush, Mem_Timeout, Stall_Cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage CPU.
// Each cycle it drives the write enables and bubble flushes of the PC and of
// the IF/ID, ID/EX, EX/MEM and MEM/WB registers. Three events are handled:
// load-use data hazards, taken branches resolved in ID, and multi-cycle
// data-memory accesses. A wait-state FSM with a watchdog covers the memory
// accesses, and a saturating counter records the cycles with PC_We=0.
// Priority, highest first: Rst, error state, memory stall, load-use, branch.
// Ports:
//   Clk  : rising-edge clock
//   Rst  : synchronous, active-high reset
//   bus  : pipe_hazard_ctrl_if.slave. It carries the hazard inputs and the
//          enable, flush and status outputs.
// Parameter:
//   MEM_TIMEOUT : maximum consecutive MEM_WAIT cycles without Mem_Ready
//                 (2..255)
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                     Clk,
  input  logic                     Rst,
  pipe_hazard_ctrl_if.slave        bus
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [WAIT_W-1:0]   wait_cnt, wait_next;
  logic [15:0]         stall_cnt;

  logic load_use;
  logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic if_id_flush, id_ex_flush, mem_wb_flush;
  logic mem_timeout;

  // The instruction in EX is a load, and the instruction in ID reads its
  // destination before the loaded data can be forwarded.
  always_comb begin
    load_use = bus.E_Reg2reg && bus.E_Wreg && (bus.E_Rd != 5'd0) &&
               ((bus.ID_Use_Rs && (bus.E_Rd == bus.ID_Rs)) ||
                (bus.ID_Use_Rt && (bus.E_Rd == bus.ID_Rt)));
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  always_comb begin
    state_next   = state;
    wait_next    = wait_cnt;
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    id_ex_we     = 1'b0;
    ex_mem_we    = 1'b0;
    mem_wb_we    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    mem_timeout  = 1'b0;

    if (Rst) begin
      state_next = RUN;
      wait_next  = '0;
    end else if (state == ERR) begin
      mem_timeout = 1'b1;
    end else if (!bus.Mem_Ready &&
                 ((state == MEM_WAIT) || bus.M_Mem_Req)) begin
      // Memory stall: freeze the front of the pipe and send a bubble to WB.
      mem_wb_we    = 1'b1;
      mem_wb_flush = 1'b1;
      if (state == RUN) begin
        state_next = MEM_WAIT;
        wait_next  = WAIT_W'(1);
      end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
        state_next = ERR;
      end else begin
        wait_next = wait_cnt + WAIT_W'(1);
      end
    end else begin
      // Completion of a memory wait follows the same rules as a RUN cycle.
      state_next = RUN;
      wait_next  = '0;
      if (load_use) begin
        ex_mem_we   = 1'b1;
        mem_wb_we   = 1'b1;
        id_ex_we    = 1'b1;
        id_ex_flush = 1'b1;
      end else begin
        pc_we       = 1'b1;
        if_id_we    = 1'b1;
        id_ex_we    = 1'b1;
        ex_mem_we   = 1'b1;
        mem_wb_we   = 1'b1;
        if_id_flush = bus.ID_Branch_Taken;
      end
    end
  end

  // Reset cycles and the error state also hold PC_We low, but they are not
  // counted as stalls.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt <= '0;
    end else if ((state != ERR) && !pc_we && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.PC_We        = pc_we;
  assign bus.IF_ID_We     = if_id_we;
  assign bus.ID_EX_We     = id_ex_we;
  assign bus.EX_MEM_We    = ex_mem_we;
  assign bus.MEM_WB_We    = mem_wb_we;
  assign bus.IF_ID_Flush  = if_id_flush;
  assign bus.ID_EX_Flush  = id_ex_flush;
  assign bus.MEM_WB_Flush = mem_wb_flush;
  assign bus.Mem_Timeout  = mem_timeout;
  assign bus.Stall_Cnt    = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl, instantiated with MEM_TIMEOUT=4.
// Output vector layout: {PC, IF_ID, ID_EX, EX_MEM, MEM_WB We,
//                        IF_ID, ID_EX, MEM_WB Flush, Mem_Timeout}.
module tb_pipe_hazard_ctrl;

  localparam int unsigned T = 4;

  localparam logic [8:0] V_ZERO   = 9'b00000_000_0;
  localparam logic [8:0] V_NORMAL = 9'b11111_000_0;
  localparam logic [8:0] V_BRANCH = 9'b11111_100_0;
  localparam logic [8:0] V_LU     = 9'b00111_010_0;
  localparam logic [8:0] V_FREEZE = 9'b00001_001_0;
  localparam logic [8:0] V_ERR    = 9'b00000_000_1;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the error flag, the number of cycles already spent
  // waiting on memory (0 = not waiting), and the stall count as an integer.
  bit         m_err    = 1'b0;
  int         m_wait   = 0;
  int         m_stalls = 0;
  bit         m_freeze;
  logic [8:0] exp_out;

  function automatic logic [8:0] dut_out();
    return {bus.PC_We, bus.IF_ID_We, bus.ID_EX_We, bus.EX_MEM_We,
            bus.MEM_WB_We, bus.IF_ID_Flush, bus.ID_EX_Flush,
            bus.MEM_WB_Flush, bus.Mem_Timeout};
  endfunction

  task automatic model_eval();
    bit lu;
    lu = bus.E_Reg2reg && bus.E_Wreg && (bus.E_Rd != 0) &&
         ((bus.ID_Use_Rs && bus.E_Rd == bus.ID_Rs) ||
          (bus.ID_Use_Rt && bus.E_Rd == bus.ID_Rt));
    m_freeze = !Rst && !m_err && !bus.Mem_Ready &&
               (m_wait > 0 || bus.M_Mem_Req);
    if (Rst)                  exp_out = V_ZERO;
    else if (m_err)           exp_out = V_ERR;
    else if (m_freeze)        exp_out = V_FREEZE;
    else if (lu)              exp_out = V_LU;
    else if (bus.ID_Branch_Taken) exp_out = V_BRANCH;
    else                      exp_out = V_NORMAL;
  endtask

  // Advance one clock edge and update the model with this cycle's inputs.
  task automatic tick();
    model_eval();
    @(posedge Clk);
    if (Rst) begin
      m_err = 1'b0; m_wait = 0; m_stalls = 0;
    end else if (!m_err) begin
      if (!exp_out[8] && m_stalls < 65535) m_stalls++;
      if (m_freeze) begin
        if (m_wait == 0)      m_wait = 1;
        else if (m_wait == T) m_err = 1'b1;
        else                  m_wait++;
      end else begin
        m_wait = 0;
      end
    end
    #1;
  endtask

  // lu=1 builds the load-use pattern (load to r5, ID reads r5 as Rs).
  task automatic drive(input bit rst, input bit req, input bit rdy,
                       input bit lu, input bit br);
    Rst                 = rst;
    bus.M_Mem_Req       = req;
    bus.Mem_Ready       = rdy;
    bus.E_Reg2reg       = lu;
    bus.E_Wreg          = lu;
    bus.E_Rd            = lu ? 5'd5 : 5'd0;
    bus.ID_Rs           = lu ? 5'd5 : 5'd1;
    bus.ID_Rt           = 5'd2;
    bus.ID_Use_Rs       = lu;
    bus.ID_Use_Rt       = 1'b0;
    bus.ID_Branch_Taken = br;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0);
    model_eval();
    @(negedge Clk);
    checks++;
    if (dut_out() !== V_ZERO) begin
      errors++; $display("FAIL reset_outs: got %b expected %b", dut_out(), V_ZERO);
    end
    tick();
    checks++;
    if (bus.Stall_Cnt !== 16'd0) begin
      errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", bus.Stall_Cnt);
    end
  endtask

  task automatic test_load_use();
    drive(0, 0, 1, 1, 0);
    model_eval();
    @(negedge Clk);
    checks++;
    if (dut_out() !== V_LU || exp_out !== V_LU) begin
      errors++; $display("FAIL load_use: got %b expected %b", dut_out(), V_LU);
    end
    tick();
    checks++;
    if (bus.Stall_Cnt !== 16'd1) begin
      errors++; $display("FAIL load_use_cnt: got %0d expected 1", bus.Stall_Cnt);
    end
    // Destination r0 never creates a hazard.
    drive(0, 0, 1, 1, 0);
    bus.E_Rd = 5'd0; bus.ID_Rs = 5'd0;
    model_eval();
    @(negedge Clk);
    checks++;
    if (dut_out() !== V_NORMAL) begin
      errors++; $display("FAIL load_use_r0: got %b expected %b", dut_out(), V_NORMAL);
    end
    tick();
    // Rt path hazard.
    drive(0, 0, 1, 0, 0);
    bus.E_Reg2reg = 1; bus.E_Wreg = 1; bus.E_Rd = 5'd9;
    bus.ID_Rt = 5'd9; bus.ID_Use_Rt = 1;
    model_eval();
    @(negedge Clk);
    checks++;
    if (dut_out() !== V_LU) begin
      errors++; $display("FAIL load_use_rt: got %b expected %b", dut_out(), V_LU);
    end
    tick();
    checks++;
    if (bus.Stall_Cnt !== 16'd2) begin
      errors++; $display("FAIL load_use_cnt2: got %0d expected 2", bus.Stall_Cnt);
    end
  endtask

  task automatic test_branch();
    drive(0, 0, 0, 0, 1);
    model_eval();
    @(negedge Clk);
    checks++;
    if (dut_out() !== V_BRANCH) begin
      errors++; $display("FAIL branch: got %b expected %b", dut_out(), V_BRANCH);
    end
    tick();
    drive(0, 0, 1, 1, 1);
    model_eval();
    @(negedge Clk);
    checks++;
    if (dut_out() !== V_LU) begin
      errors++; $display("FAIL branch_lu: got %b expected %b", dut_out(), V_LU);
    end
    tick();
    // Single-cycle memory access: no stall.
    drive(0, 1, 1, 0, 0);
    model_eval();
    @(negedge Clk);
    checks++;
    if (dut_out() !== V_NORMAL) begin
      errors++; $display("FAIL mem_hit: got %b expected %b", dut_out(), V_NORMAL);
    end
    tick();
  endtask

  task automatic test_mem_miss();
    drive(1, 0, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, (i == 0), (i == 2), 0, 0);
      model_eval();
      @(negedge Clk);
      checks++;
      if (dut_out() !== ((i < 2) ? V_FREEZE : V_NORMAL)) begin
        errors++; $display("FAIL mem_miss[%0d]: got %b expected %b", i, dut_out(),
                           (i < 2) ? V_FREEZE : V_NORMAL);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0);
    model_eval();
    @(negedge Clk);
    checks++;
    if (dut_out() !== V_NORMAL || bus.Stall_Cnt !== 16'd2) begin
      errors++; $display("FAIL mem_miss_after: got %b cnt %0d expected %b cnt 2",
                         dut_out(), bus.Stall_Cnt, V_NORMAL);
    end
    tick();
  endtask

  task automatic test_timeout();
    drive(1, 0, 0, 0, 0); tick();
    for (int i = 0; i < 9; i++) begin
      if (i < 6) drive(0, 1, 0, 0, 0);
      else       drive(0, 1, 1, 1, 1);
      model_eval();
      @(negedge Clk);
      checks++;
      if (dut_out() !== ((i <= T) ? V_FREEZE : V_ERR)) begin
        errors++; $display("FAIL timeout[%0d]: got %b expected %b", i, dut_out(),
                           (i <= T) ? V_FREEZE : V_ERR);
      end
      tick();
    end
    checks++;
    if (bus.Stall_Cnt !== 16'd5) begin
      errors++; $display("FAIL timeout_cnt: got %0d expected 5", bus.Stall_Cnt);
    end
    drive(1, 1, 1, 0, 0);
    model_eval();
    @(negedge Clk);
    checks++;
    if (dut_out() !== V_ZERO) begin
      errors++; $display("FAIL timeout_rst: got %b expected %b", dut_out(), V_ZERO);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    model_eval();
    @(negedge Clk);
    checks++;
    if (dut_out() !== V_NORMAL || bus.Stall_Cnt !== 16'd0) begin
      errors++; $display("FAIL timeout_clear: got %b cnt %0d expected %b cnt 0",
                         dut_out(), bus.Stall_Cnt, V_NORMAL);
    end
    tick();
  endtask

  task automatic test_ready_at_limit();
    drive(1, 0, 0, 0, 0); tick();
    for (int i = 0; i < 6; i++) begin
      drive(0, (i == 0), (i == T), 0, 0);
      model_eval();
      @(negedge Clk);
      checks++;
      if (dut_out() !== ((i < T) ? V_FREEZE : V_NORMAL)) begin
        errors++; $display("FAIL ready_limit[%0d]: got %b expected %b", i, dut_out(),
                           (i < T) ? V_FREEZE : V_NORMAL);
      end
      tick();
    end
    checks++;
    if (bus.Stall_Cnt !== 16'(T)) begin
      errors++; $display("FAIL ready_limit_cnt: got %0d expected %0d", bus.Stall_Cnt, T);
    end
  endtask

  task automatic test_rst_mid_wait();
    drive(0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0);
    model_eval();
    @(negedge Clk);
    checks++;
    if (dut_out() !== V_ZERO) begin
      errors++; $display("FAIL rst_mid_wait: got %b expected %b", dut_out(), V_ZERO);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    model_eval();
    @(negedge Clk);
    checks++;
    if (dut_out() !== V_NORMAL || bus.Stall_Cnt !== 16'd0) begin
      errors++; $display("FAIL rst_mid_wait_after: got %b cnt %0d expected %b cnt 0",
                         dut_out(), bus.Stall_Cnt, V_NORMAL);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      Rst                 = ($urandom_range(99) < 3);
      bus.M_Mem_Req       = ($urandom_range(99) < 30);
      bus.Mem_Ready       = ($urandom_range(99) < 55);
      bus.E_Reg2reg       = $urandom_range(1);
      bus.E_Wreg          = ($urandom_range(3) != 0);
      bus.E_Rd            = 5'($urandom_range(3));
      bus.ID_Rs           = 5'($urandom_range(3));
      bus.ID_Rt           = 5'($urandom_range(3));
      bus.ID_Use_Rs       = $urandom_range(1);
      bus.ID_Use_Rt       = $urandom_range(1);
      bus.ID_Branch_Taken = ($urandom_range(3) == 0);
      model_eval();
      @(negedge Clk);
      checks++;
      if (dut_out() !== exp_out) begin
        errors++; $display("FAIL random_outs[%0d]: got %b expected %b", i, dut_out(), exp_out);
      end
      checks++;
      if (bus.Stall_Cnt !== 16'(m_stalls)) begin
        errors++; $display("FAIL random_cnt[%0d]: got %0d expected %0d", i, bus.Stall_Cnt, m_stalls);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 1, 0);
    for (int i = 0; i < 65540; i++) tick();
    model_eval();
    @(negedge Clk);
    checks++;
    if (bus.Stall_Cnt !== 16'hFFFF || m_stalls != 65535) begin
      errors++; $display("FAIL saturation: got %h expected ffff", bus.Stall_Cnt);
    end
    checks++;
    if (dut_out() !== V_LU) begin
      errors++; $display("FAIL saturation_outs: got %b expected %b", dut_out(), V_LU);
    end
    tick();
    checks++;
    if (bus.Stall_Cnt !== 16'hFFFF) begin
      errors++; $display("FAIL saturation_hold: got %h expected ffff", bus.Stall_Cnt);
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0);
    test_reset();
    test_load_use();
    test_branch();
    test_mem_miss();
    test_timeout();
    test_ready_at_limit();
    test_rst_mid_wait();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage CPU. Each cycle it drives the write-enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It handles three events: load-use data hazards, taken branches resolved in ID, and multi-cycle data-memory accesses. A wait-state FSM with a timeout watchdog handles the memory accesses, and a saturating counter records stall cycles for performance measurement.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive MEM_WAIT cycles without Mem_Ready before the error state is entered (range 2..255).
- Clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- ID_Rs, ID_Rt  in  5  source register numbers of the instruction in ID.
- ID_Use_Rs, ID_Use_Rt  in  1  the ID instruction reads Rs or Rt, respectively.
- E_Rd  in  5  destination register of the instruction in EX.
- E_Wreg  in  1  the EX instruction writes the register file.
- E_Reg2reg  in  1  the EX instruction is a load, so its result comes from memory.
- ID_Branch_Taken  in  1  a branch or jump in ID resolved taken this cycle.
- M_Mem_Req  in  1  the MEM-stage instruction accesses data memory this cycle.
- Mem_Ready  in  1  data memory completes the access this cycle.
- PC_We, IF_ID_We, ID_EX_We, EX_MEM_We, MEM_WB_We  out  1  per-stage register write enables.
- IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush  out  1  load a bubble (all-zero) into that register at the next edge. A flush acts only when the matching We=1.
- Mem_Timeout  out  1  sticky error flag.
- Stall_Cnt  out  16  count of cycles with PC_We=0.

## Operation
- FSM states: RUN, MEM_WAIT, ERR. Reset state is RUN.
- Outputs are combinational from the state and the inputs in the same cycle. Stall_Cnt and the state are registered.
- Priority, highest first: Rst, ERR, memory stall, load-use, branch.
- Rst=1: every We=0, every Flush=0, and Mem_Timeout=0. At the edge: state goes to RUN, wait_cnt=0 and Stall_Cnt=0.
- Memory stall (RUN with M_Mem_Req=1 and Mem_Ready=0, or MEM_WAIT with Mem_Ready=0):
  - PC, IF_ID, ID_EX and EX_MEM We=0, so those stages hold.
  - MEM_WB_We=1 and MEM_WB_Flush=1, so a bubble goes to WB.
  - RUN moves to MEM_WAIT and sets wait_cnt=1.
  - In MEM_WAIT, wait_cnt increments each cycle. With wait_cnt==MEM_TIMEOUT and Mem_Ready=0, the next state is ERR.
- MEM_WAIT with Mem_Ready=1: all We=1, with flushes from the load-use and branch rules applied as in RUN. Next state is RUN and wait_cnt=0.
- Load-use hazard condition: E_Reg2reg & E_Wreg & (E_Rd!=0) & ((ID_Use_Rs & E_Rd==ID_Rs) | (ID_Use_Rt & E_Rd==ID_Rt)).
  - Response: PC_We=0 and IF_ID_We=0. ID_EX_We=1 with ID_EX_Flush=1. EX_MEM_We=1 and MEM_WB_We=1.
  - A taken branch in the same cycle is ignored. The branch re-resolves on the next cycle.
- Taken branch with no higher-priority event: all We=1 and IF_ID_Flush=1. This is a single delay-slot squash.
- Normal cycle: all We=1 and all Flush=0.
- ERR: all We=0, all Flush=0, Mem_Timeout=1. ERR holds until Rst and ignores every other input.
- Stall_Cnt increments at each edge where PC_We=0, except in reset cycles and in ERR. It saturates at 16'hFFFF.

## Timing
- Zero-latency control: a hazard input asserted in cycle N affects the enables in cycle N. The registers respond at the end of cycle N.
- A single-cycle memory access (M_Mem_Req=1 with Mem_Ready=1 in the same RUN cycle) causes no stall.
- A load-use hazard always costs exactly 1 stall cycle. After the stall edge the load has moved to MEM, so the hazard condition drops on its own.
- A memory miss with Mem_Ready arriving k cycles later costs k stall cycles. The stalled cycles are the detecting RUN cycle plus k-1 MEM_WAIT cycles.
- Timeout: Mem_Timeout rises MEM_TIMEOUT+1 cycles after the detecting RUN cycle, provided Mem_Ready stays 0 throughout.
- Mem_Ready=1 in the same cycle that wait_cnt reaches MEM_TIMEOUT counts as completion, and the next state is RUN, not ERR.
- Rst mid-MEM_WAIT: reset behaviour applies in that cycle, and the next cycle is RUN with counters cleared.

## Test plan
- Load-use: E_Reg2reg=1, E_Wreg=1, E_Rd=5, ID_Rs=5, ID_Use_Rs=1, one cycle -> PC_We=0, IF_ID_We=0, ID_EX_Flush=1; Stall_Cnt 0→1. Repeat with E_Rd=0 -> no stall.
- Branch alone -> IF_ID_Flush=1 and all We=1. Branch together with a load-use hazard -> IF_ID_Flush=0 and the stall pattern is driven.
- MEM_TIMEOUT=4, M_Mem_Req=1, Mem_Ready=0 for 2 cycles, then 1 -> freeze plus MEM_WB bubble for 2 cycles, then all We=1 and state RUN; Stall_Cnt=2.
- MEM_TIMEOUT=4, Mem_Ready held 0 -> freeze for 5 cycles, then Mem_Timeout=1 and all We=0. Mem_Timeout stays 1 despite Mem_Ready=1 until Rst.
- Mem_Ready=1 exactly when wait_cnt==MEM_TIMEOUT -> state RUN, Mem_Timeout=0.
- Rst pulsed during MEM_WAIT -> next cycle RUN with Stall_Cnt=0. Forced saturation: 70000 load-use stall cycles -> Stall_Cnt=16'hFFFF.
